// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : reg_write_arbiter
// Brief   : Shares one external WIDTH-bit register between NREQ requesters.
//           Each write runs IDLE -> GRANT -> WRITE -> IDLE; arbitration happens
//           only in IDLE, using a round-robin pointer by default.
//           Define REGARB_FIXED_PRI_EN for fixed priority (lowest index wins,
//           no pointer register).
// Revision: 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         ack,
    output logic [WIDTH-1:0]        reg_d,
    output logic                    reg_load,
    output logic                    busy
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_WRITE = 2'd2;

    localparam logic [NREQ-1:0] c_ONE = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_IW-1:0]   r_winner;
    logic [c_IW-1:0]   w_winner_nxt;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   w_grant_nxt;
    logic [NREQ-1:0]   r_ack;
    logic [NREQ-1:0]   w_ack_nxt;
    logic              r_load;
    logic              w_load_nxt;
    logic [WIDTH-1:0]  r_d;
    logic [WIDTH-1:0]  w_d_nxt;
    logic [c_IW-1:0]   w_win;
    logic              w_found;

`ifndef REGARB_FIXED_PRI_EN
    logic [c_IW-1:0]   r_ptr;
    logic [c_IW-1:0]   w_ptr_nxt;
`endif

    // Winner search: first active request at/after the pointer, wrapping.
    always_comb begin : p_arb
        int v_idx;
        v_idx   = 0;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef REGARB_FIXED_PRI_EN
            v_idx = k;
`else
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
`endif
            if (!w_found && req[c_IW'(v_idx)]) begin
                w_found = 1'b1;
                w_win   = c_IW'(v_idx);
            end
        end
    end

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        w_state_nxt  = r_state;
        w_winner_nxt = r_winner;
        w_grant_nxt  = r_grant;
        w_ack_nxt    = '0;
        w_load_nxt   = 1'b0;
        w_d_nxt      = r_d;
`ifndef REGARB_FIXED_PRI_EN
        w_ptr_nxt    = r_ptr;
`endif
        case (r_state)
            c_IDLE: begin
                w_grant_nxt = '0;
                w_d_nxt     = '0;
                if (|req) begin
                    w_state_nxt  = c_GRANT;
                    w_winner_nxt = w_win;
                    w_grant_nxt  = c_ONE << w_win;
                    // Data is captured here; later wdata changes are not seen.
                    w_d_nxt      = wdata[w_win*WIDTH +: WIDTH];
                end
            end
            c_GRANT: begin
                if (req[r_winner]) begin
                    w_state_nxt = c_WRITE;
                    w_ack_nxt   = c_ONE << r_winner;
                    w_load_nxt  = 1'b1;
                end else begin
                    // Requester withdrew: abandon without touching the pointer.
                    w_state_nxt = c_IDLE;
                    w_grant_nxt = '0;
                    w_d_nxt     = '0;
                end
            end
            c_WRITE: begin
                // Write commits regardless of req; move on to the next requester.
                w_state_nxt = c_IDLE;
                w_grant_nxt = '0;
                w_d_nxt     = '0;
`ifndef REGARB_FIXED_PRI_EN
                w_ptr_nxt   = (r_winner == c_IW'(NREQ-1)) ? '0 : r_winner + 1'b1;
`endif
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_grant_nxt = '0;
                w_d_nxt     = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state  <= c_IDLE;
            r_winner <= '0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_load   <= 1'b0;
            r_d      <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_winner <= w_winner_nxt;
            r_grant  <= w_grant_nxt;
            r_ack    <= w_ack_nxt;
            r_load   <= w_load_nxt;
            r_d      <= w_d_nxt;
        end
    end

`ifndef REGARB_FIXED_PRI_EN
    // Round-robin pointer.
    always_ff @(posedge clk) begin
        if (res) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

    // Reset raised during WRITE suppresses the load and ack in that same cycle,
    // so the register is not updated on the reset edge.
    assign grant    = r_grant;
    assign ack      = r_ack & {NREQ{~res}};
    assign reg_load = r_load & ~res;
    assign reg_d    = r_d;
    assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_write_arbiter
// Brief   : Scoreboard bench for reg_write_arbiter. Stimulus pushes expected
//           writes (requester, data) into a queue; a monitor pops one entry on
//           every committed write and compares ack and reg_d. Also models the
//           external register so q can be checked.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  res;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      reg_d;
    logic                  reg_load;
    logic                  busy;

    logic [WIDTH-1:0]      q_reg = '0;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .res      (res),
        .req      (req),
        .wdata    (wdata),
        .grant    (grant),
        .ack      (ack),
        .reg_d    (reg_d),
        .reg_load (reg_load),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // External register driven by the arbiter.
    always @(posedge clk) begin
        if (reg_load) q_reg <= reg_d;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [WIDTH-1:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every committed write must match the next expected entry.
    always @(negedge clk) begin
        if (reg_load || (|ack)) begin
            exp_t e;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: ack=%b reg_d=%h with empty scoreboard", ack, reg_d);
            end else begin
                logic [NREQ-1:0] oh;
                e  = sbq.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                chk("sb_ack", {28'd0, ack}, {28'd0, oh});
                chk("sb_reg_d", {28'd0, reg_d}, {28'd0, e.data});
                chk("sb_load", {31'd0, reg_load}, 32'd1);
            end
        end
    end

    // Hold requests until n acks are seen; optionally drop each acked request.
    task automatic run_acks(input int n, input bit drop_on_ack);
        int cnt;
        cnt = 0;
        for (int c = 0; c < 20 * n && cnt < n; c++) begin
            tick();
            if (|ack) begin
                cnt++;
                if (drop_on_ack) req = req & ~ack;
            end
        end
        if (cnt < n) chk("ack_timeout", cnt, n);
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with all requests active
        res   = 1'b1;
        req   = 4'b1111;
        wdata = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_grant", {28'd0, grant}, 32'd0);
            chk("rst_ack", {28'd0, ack}, 32'd0);
            chk("rst_load", {31'd0, reg_load}, 32'd0);
            chk("rst_reg_d", {28'd0, reg_d}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        res = 1'b0;
        req = '0;
        tick();

        // 2: single write from requester 2
        req   = 4'b0100;
        wdata = 16'h0A00;
        push(2, 4'hA);
        tick();
        chk("t2_grant_c1", {28'd0, grant}, 32'h4);
        chk("t2_busy_c1", {31'd0, busy}, 32'd1);
        chk("t2_load_c1", {31'd0, reg_load}, 32'd0);
        tick();
        chk("t2_load_c2", {31'd0, reg_load}, 32'd1);
        chk("t2_grant_c2", {28'd0, grant}, 32'h4);
        chk("t2_busy_c2", {31'd0, busy}, 32'd1);
        req = '0;
        tick();
        chk("t2_q_c3", {28'd0, q_reg}, 32'hA);
        chk("t2_busy_c3", {31'd0, busy}, 32'd0);
        chk("t2_grant_c3", {28'd0, grant}, 32'd0);

        // 6: pointer now 3, requesters 0 and 3 -> 3 then 0 (wrap)
        req   = 4'b1001;
        wdata = 16'hC005;
`ifdef REGARB_FIXED_PRI_EN
        push(0, 4'h5);
        push(3, 4'hC);
`else
        push(3, 4'hC);
        push(0, 4'h5);
`endif
        run_acks(2, 1'b1);

        // 3: all requesting, held; reset first so the pointer starts at 0
        res = 1'b1;
        tick();
        res   = 1'b0;
        req   = 4'b1111;
        wdata = 16'h4321;
`ifdef REGARB_FIXED_PRI_EN
        for (int i = 0; i < 3; i++) push(0, 4'h1);
        run_acks(3, 1'b0);
`else
        push(0, 4'h1);
        push(1, 4'h2);
        push(2, 4'h3);
        push(3, 4'h4);
        push(0, 4'h1);
        run_acks(5, 1'b0);
`endif
        chk("t3_q", {28'd0, q_reg}, 32'h1);

        // 4: requester 1 drops in GRANT, then re-raises and wins
        req   = 4'b0010;
        wdata = 16'h0078;
        tick();
        chk("t4_grant", {28'd0, grant}, 32'h2);
        req = '0;
        tick();
        chk("t4_drop_grant", {28'd0, grant}, 32'd0);
        chk("t4_drop_busy", {31'd0, busy}, 32'd0);
        chk("t4_drop_load", {31'd0, reg_load}, 32'd0);
        tick();
        chk("t4_idle_load", {31'd0, reg_load}, 32'd0);
        chk("t4_q_kept", {28'd0, q_reg}, 32'h1);
`ifdef REGARB_FIXED_PRI_EN
        req = 4'b0010;
        push(1, 4'h7);
        run_acks(1, 1'b1);
        chk("t4_q", {28'd0, q_reg}, 32'h7);
`else
        req = 4'b0011;
        push(1, 4'h7);
        push(0, 4'h8);
        run_acks(2, 1'b1);
        chk("t4_q", {28'd0, q_reg}, 32'h8);
`endif

        // 5: reset asserted in the WRITE cycle
        req   = 4'b0100;
        wdata = 16'h0F00;
        tick();
        chk("t5_grant", {28'd0, grant}, 32'h4);
        tick();
        res = 1'b1;
        #1;
        chk("t5_load_in_rst", {31'd0, reg_load}, 32'd0);
        chk("t5_ack_in_rst", {28'd0, ack}, 32'd0);
        tick();
`ifdef REGARB_FIXED_PRI_EN
        chk("t5_q_unchanged", {28'd0, q_reg}, 32'h7);
`else
        chk("t5_q_unchanged", {28'd0, q_reg}, 32'h8);
`endif
        chk("t5_grant_after", {28'd0, grant}, 32'd0);
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        res   = 1'b0;
        // pointer back at 0: requester 1 before 3
        req   = 4'b1010;
        wdata = 16'h9020;
        push(1, 4'h2);
        push(3, 4'h9);
        run_acks(2, 1'b1);
        chk("t5_q_final", {28'd0, q_reg}, 32'h9);

        tick();
        chk("sb_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
